operand_loader: RTL and testbench

- Clocked front end that builds the two 8-bit comparator operands from four raw pushbuttons and a 4-bit slide-switch bank.
- Each button and the switch bank are synchronised; each button is also debounced.
- On a debounced rising edge of PBn, the synchronised switch value is written into the nibble that PBn owns.
- Registered outputs a and b feed the 8-bit ripple comparator directly. Status flags tell the display logic which nibbles have been loaded.

---
 rtl/operand_loader.sv | 146 ++++++++++++++
 tb/tb_operand_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Operand loader: synchronises four pushbuttons and a 4-bit switch bank,
// debounces each button, and on a debounced press writes the switch value
// into the nibble that button owns. Produces the two 8-bit comparator
// operands plus loaded/ready/update status for the display logic.
`timescale 1ns/1ps

module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PB1,
  input  logic       PB2,
  input  logic       PB3,
  input  logic       PB4,
  input  logic [3:0] s,
  input  logic       clr,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [3:0] loaded,
  output logic       ready,
  output logic       upd
);

  // Counter value on which the next disagreeing edge flips the stable level.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit n-1 of the button vector corresponds to PBn.
  logic [3:0] pbRaw;

  // Two-flop synchronisers for the buttons and the switch bank.
  logic [3:0] pbMeta_q;
  logic [3:0] pbSync_q;
  logic [3:0] sMeta_q;
  logic [3:0] sSync_q;

  // Per-button debounced level and qualification counter.
  logic [3:0]           stable_q;
  logic [3:0]           stable_d;
  logic [CNT_W-1:0]     cnt_q [4];
  logic [CNT_W-1:0]     cnt_d [4];

  // One bit per button: its debounced level rises on this edge.
  logic [3:0] write;

  // Operand and status registers.
  logic [7:0] a_q;
  logic [7:0] a_d;
  logic [7:0] b_q;
  logic [7:0] b_d;
  logic [3:0] loaded_q;
  logic [3:0] loaded_d;
  logic       ready_q;
  logic       ready_d;
  logic       upd_q;
  logic       upd_d;

  assign pbRaw = {PB4, PB3, PB2, PB1};

  // Synchroniser chains; reset clears them so a held button re-qualifies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pbMeta_q <= '0;
      pbSync_q <= '0;
      sMeta_q  <= '0;
      sSync_q  <= '0;
    end else begin
      pbMeta_q <= pbRaw;
      pbSync_q <= pbMeta_q;
      sMeta_q  <= s;
      sSync_q  <= sMeta_q;
    end
  end

  // Debounce: count consecutive disagreeing edges, flip after DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    write    = '0;
    for (int n = 0; n < 4; n++) begin
      cnt_d[n] = '0;
      if (pbSync_q[n] != stable_q[n]) begin
        if (cnt_q[n] == CntLast) begin
          stable_d[n] = ~stable_q[n];
          cnt_d[n]    = '0;
          write[n]    = ~stable_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      for (int n = 0; n < 4; n++) begin
        cnt_q[n] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int n = 0; n < 4; n++) begin
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  // Nibble writes, loaded flags (load beats clear), ready and update pulse.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (write[0]) a_d[3:0] = sSync_q;
    if (write[1]) a_d[7:4] = sSync_q;
    if (write[2]) b_d[3:0] = sSync_q;
    if (write[3]) b_d[7:4] = sSync_q;
    loaded_d = clr ? 4'b0000 : loaded_q;
    loaded_d = loaded_d | write;
    ready_d  = &loaded_q;
    upd_d    = |write;
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      loaded_q <= '0;
      ready_q  <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      loaded_q <= loaded_d;
      ready_q  <= ready_d;
      upd_q    <= upd_d;
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign loaded = loaded_q;
  assign ready  = ready_q;
  assign upd    = upd_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with a short debounce window.
`timescale 1ns/1ps

module tb_operand_loader;

  logic       clk;
  logic       reset;
  logic       PB1;
  logic       PB2;
  logic       PB3;
  logic       PB4;
  logic [3:0] s;
  logic       clr;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] loaded;
  logic       ready;
  logic       upd;

  int vecCount;
  int failCount;

  operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PB1(PB1),
    .PB2(PB2),
    .PB3(PB3),
    .PB4(PB4),
    .s(s),
    .clr(clr),
    .a(a),
    .b(b),
    .loaded(loaded),
    .ready(ready),
    .upd(upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setPb(input int idx, input logic v);
    case (idx)
      1: PB1 = v;
      2: PB2 = v;
      3: PB3 = v;
      default: PB4 = v;
    endcase
  endtask

  task automatic releaseAll();
    PB1 = 1'b0;
    PB2 = 1'b0;
    PB3 = 1'b0;
    PB4 = 1'b0;
    tick(8);
  endtask

  task automatic doPress(input int idx, input logic [3:0] v);
    s = v;
    tick(3);
    setPb(idx, 1'b1);
    tick(6);
    releaseAll();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    PB1 = 0; PB2 = 0; PB3 = 0; PB4 = 0;
    s = 4'h0;
    clr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    vecCount++;
    if ({a, b, loaded, ready, upd} !== 22'd0) begin
      failCount++;
      $display("[TB] FAIL reset_state: got a=%h b=%h loaded=%b ready=%b upd=%b, want all 0",
               a, b, loaded, ready, upd);
    end
  endtask

  task automatic test_single_press();
    logic sawUpd;
    s = 4'hA;
    tick(3);
    PB1 = 1'b1;
    tick(5);
    vecCount++;
    if (a !== 8'h00 || upd !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL press_early: got a=%h upd=%b, want a=00 upd=0", a, upd);
    end
    tick(1);
    vecCount++;
    if (a !== 8'h0A || upd !== 1'b1 || loaded !== 4'b0001 || b !== 8'h00 || ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL press_write: got a=%h b=%h loaded=%b upd=%b ready=%b, want a=0a b=00 loaded=0001 upd=1 ready=0",
               a, b, loaded, upd, ready);
    end
    sawUpd = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (upd) sawUpd = 1'b1;
    end
    PB1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (upd) sawUpd = 1'b1;
    end
    vecCount++;
    if (sawUpd !== 1'b0 || a !== 8'h0A || loaded !== 4'b0001) begin
      failCount++;
      $display("[TB] FAIL press_hold_release: got extraUpd=%b a=%h loaded=%b, want extraUpd=0 a=0a loaded=0001",
               sawUpd, a, loaded);
    end
  endtask

  task automatic test_bounce();
    logic changed;
    s = 4'h3;
    tick(3);
    changed = 1'b0;
    for (int i = 0; i < 6; i++) begin
      PB2 = ~PB2;
      tick(1);
      if (upd || a !== 8'h0A || loaded !== 4'b0001) changed = 1'b1;
    end
    PB2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (upd || a !== 8'h0A || loaded !== 4'b0001) changed = 1'b1;
    end
    vecCount++;
    if (changed !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL bounce: got changed=%b a=%h loaded=%b, want changed=0 a=0a loaded=0001",
               changed, a, loaded);
    end
  endtask

  task automatic test_full_sequence();
    doPress(1, 4'h5);
    vecCount++;
    if (a !== 8'h05 || loaded !== 4'b0001) begin
      failCount++;
      $display("[TB] FAIL seq_pb1: got a=%h loaded=%b, want a=05 loaded=0001", a, loaded);
    end
    doPress(2, 4'h3);
    vecCount++;
    if (a !== 8'h35 || loaded !== 4'b0011) begin
      failCount++;
      $display("[TB] FAIL seq_pb2: got a=%h loaded=%b, want a=35 loaded=0011", a, loaded);
    end
    doPress(3, 4'hC);
    vecCount++;
    if (b !== 8'h0C || loaded !== 4'b0111 || ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL seq_pb3: got b=%h loaded=%b ready=%b, want b=0c loaded=0111 ready=0",
               b, loaded, ready);
    end
    s = 4'h0;
    tick(3);
    PB4 = 1'b1;
    tick(6);
    vecCount++;
    if (loaded !== 4'b1111 || ready !== 1'b0 || upd !== 1'b1 || b !== 8'h0C) begin
      failCount++;
      $display("[TB] FAIL seq_pb4_write: got loaded=%b ready=%b upd=%b b=%h, want loaded=1111 ready=0 upd=1 b=0c",
               loaded, ready, upd, b);
    end
    tick(1);
    vecCount++;
    if (ready !== 1'b1 || a !== 8'h35 || b !== 8'h0C) begin
      failCount++;
      $display("[TB] FAIL seq_ready: got ready=%b a=%h b=%h, want ready=1 a=35 b=0c", ready, a, b);
    end
    releaseAll();
  endtask

  task automatic test_back_to_back();
    s = 4'h7;
    tick(3);
    PB3 = 1'b1;
    PB4 = 1'b1;
    tick(5);
    vecCount++;
    if (b !== 8'h0C || upd !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL simul_early: got b=%h upd=%b, want b=0c upd=0", b, upd);
    end
    tick(1);
    vecCount++;
    if (b !== 8'h77 || loaded[3:2] !== 2'b11 || upd !== 1'b1 || a !== 8'h35) begin
      failCount++;
      $display("[TB] FAIL simul_write: got b=%h loaded=%b upd=%b a=%h, want b=77 loaded[3:2]=11 upd=1 a=35",
               b, loaded, upd, a);
    end
    tick(1);
    vecCount++;
    if (upd !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL simul_single_upd: got upd=%b, want 0", upd);
    end
    releaseAll();
  endtask

  task automatic test_clear();
    s = 4'h9;
    tick(3);
    PB1 = 1'b1;
    tick(5);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    vecCount++;
    if (loaded !== 4'b0001 || a !== 8'h39 || b !== 8'h77 || upd !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL clr_load_wins: got loaded=%b a=%h b=%h upd=%b, want loaded=0001 a=39 b=77 upd=1",
               loaded, a, b, upd);
    end
    tick(1);
    vecCount++;
    if (ready !== 1'b0 || a !== 8'h39 || b !== 8'h77 || loaded !== 4'b0001) begin
      failCount++;
      $display("[TB] FAIL clr_ready: got ready=%b a=%h b=%h loaded=%b, want ready=0 a=39 b=77 loaded=0001",
               ready, a, b, loaded);
    end
    releaseAll();
  endtask

  task automatic test_reset_mid_debounce();
    doPress(1, 4'h5);
    vecCount++;
    if (a !== 8'h35) begin
      failCount++;
      $display("[TB] FAIL rst_pre: got a=%h, want 35", a);
    end
    s = 4'h6;
    tick(3);
    PB2 = 1'b1;
    tick(5);
    reset = 1'b1;
    #0.5;
    vecCount++;
    if ({a, b, loaded, ready, upd} !== 22'd0) begin
      failCount++;
      $display("[TB] FAIL rst_async: got a=%h b=%h loaded=%b ready=%b upd=%b, want all 0",
               a, b, loaded, ready, upd);
    end
    #0.5;
    reset = 1'b0;
    tick(5);
    vecCount++;
    if (a !== 8'h00 || upd !== 1'b0 || loaded !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL rst_requalify_early: got a=%h upd=%b loaded=%b, want a=00 upd=0 loaded=0000",
               a, upd, loaded);
    end
    tick(1);
    vecCount++;
    if (a !== 8'h60 || upd !== 1'b1 || loaded !== 4'b0010 || b !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL rst_requalify_write: got a=%h upd=%b loaded=%b b=%h, want a=60 upd=1 loaded=0010 b=00",
               a, upd, loaded, b);
    end
    releaseAll();
  endtask

  initial begin
    vecCount  = 0;
    failCount = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_full_sequence();
    test_back_to_back();
    test_clear();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
